// File: rtl/tug_of_war_referee.sv
// Round/match controller for the two-player tug-of-war game.
// Moves a one-hot light along the playfield on filtered press pulses, scores
// round wins, holds a fixed lockout after each win and freezes at match end.
module tug_of_war_referee #(
  parameter int unsigned NUM_LEDS       = 9,
  parameter int unsigned LOCKOUT_CYCLES = 4,
  parameter int unsigned SCORE_MAX      = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          press,
  output logic [NUM_LEDS-1:0] leds,
  output logic [2:0]          p1_score,
  output logic [2:0]          p2_score,
  output logic [1:0]          winner,
  output logic                round_active
);

  localparam int unsigned PosW = $clog2(NUM_LEDS);
  localparam int unsigned CntW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [PosW-1:0]     Centre    = PosW'((NUM_LEDS - 1) / 2);
  localparam logic [PosW-1:0]     PosMax    = PosW'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LedOne    = {{(NUM_LEDS - 1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LedCentre = LedOne << ((NUM_LEDS - 1) / 2);
  localparam logic [2:0]          ScoreTop  = 3'(SCORE_MAX);

  typedef enum logic [1:0] {StPlay, StWin, StDone} state_e;

  state_e              state_q, state_d;
  logic [PosW-1:0]     pos_q, pos_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [2:0]          p1_q, p1_d, p2_q, p2_d;
  logic [1:0]          winner_q, winner_d;
  logic                active_q, active_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                p1_win, p2_win, match_over;

  // Next-state and registered-output values for every state.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    leds_d     = leds_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    winner_d   = winner_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    p1_win     = 1'b0;
    p2_win     = 1'b0;
    match_over = 1'b0;
    case (state_q)
      StPlay: begin
        // Light stops at the edge; a further press from the edge wins the round.
        if (press == 2'b10) begin
          if (pos_q == PosMax) p1_win = 1'b1;
          else                 pos_d  = pos_q + PosW'(1);
        end else if (press == 2'b01) begin
          if (pos_q == '0) p2_win = 1'b1;
          else             pos_d  = pos_q - PosW'(1);
        end
        if (p1_win || p2_win) begin
          if (p1_win) begin
            p1_d       = (p1_q < ScoreTop) ? p1_q + 3'd1 : p1_q;
            winner_d   = 2'b10;
            match_over = (p1_d == ScoreTop);
          end else begin
            p2_d       = (p2_q < ScoreTop) ? p2_q + 3'd1 : p2_q;
            winner_d   = 2'b01;
            match_over = (p2_d == ScoreTop);
          end
          leds_d   = '0;
          active_d = 1'b0;
          cnt_d    = CntW'(LOCKOUT_CYCLES - 1);
          state_d  = match_over ? StDone : StWin;
        end else begin
          leds_d = LedOne << pos_d;
        end
      end
      StWin: begin
        // Lockout: presses ignored until the counter expires, then re-centre.
        if (cnt_q == '0) begin
          state_d  = StPlay;
          pos_d    = Centre;
          leds_d   = LedCentre;
          winner_d = 2'b00;
          active_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // Match frozen; only reset leaves this state.
      end
      default: state_d = StPlay;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StPlay;
      pos_q    <= Centre;
      leds_q   <= LedCentre;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= 2'b00;
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      leds_q   <= leds_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign leds         = leds_q;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign winner       = winner_q;
  assign round_active = active_q;

endmodule

// File: tb/tb_tug_of_war_referee.sv
// Scoreboard bench for tug_of_war_referee: a driver issues presses and pushes the
// reference model's expected outputs; a monitor pops and compares each cycle.
module tb_tug_of_war_referee;

  localparam int N      = 9;
  localparam int LOCK   = 4;
  localparam int SMAX   = 7;
  localparam int CENTRE = (N - 1) / 2;

  typedef struct packed {
    logic [N-1:0] leds;
    logic [2:0]   p1;
    logic [2:0]   p2;
    logic [1:0]   winner;
    logic         active;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   press = 2'b00;
  logic [N-1:0] leds;
  logic [2:0]   p1_score, p2_score;
  logic [1:0]   winner;
  logic         round_active;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // Reference model: light position, scores, remaining lockout cycles, match-over flag.
  int m_pos, m_p1, m_p2, m_lock, m_winner;
  bit m_done;

  tug_of_war_referee #(.NUM_LEDS(N), .LOCKOUT_CYCLES(LOCK), .SCORE_MAX(SMAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .press        (press),
    .leds         (leds),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .winner       (winner),
    .round_active (round_active)
  );

  always #5 clk = ~clk;

  function automatic bit playing();
    return !m_done && (m_lock == 0);
  endfunction

  task automatic model_win(input int who);
    if (who == 1) begin m_p1++; m_winner = 2; end
    else          begin m_p2++; m_winner = 1; end
    if ((who == 1 ? m_p1 : m_p2) == SMAX) m_done = 1'b1;
    else                                  m_lock = LOCK;
  endtask

  task automatic model_step(input logic [1:0] p, input logic r);
    if (r) begin
      m_pos = CENTRE; m_p1 = 0; m_p2 = 0; m_lock = 0; m_winner = 0; m_done = 1'b0;
    end else if (m_done) begin
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) begin m_pos = CENTRE; m_winner = 0; end
    end else if (p == 2'b10) begin
      if (m_pos == N - 1) model_win(1); else m_pos++;
    end else if (p == 2'b01) begin
      if (m_pos == 0) model_win(2); else m_pos--;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.leds   = playing() ? N'(1) << m_pos : '0;
    o.p1     = 3'(m_p1);
    o.p2     = 3'(m_p2);
    o.winner = 2'(m_winner);
    o.active = playing();
    return o;
  endfunction

  // One clock of stimulus: drive away from the edge, update model, queue expectation.
  task automatic cyc(input logic [1:0] p, input logic r);
    @(negedge clk);
    press = p;
    reset = r;
    model_step(p, r);
    exp_q.push_back(model_out());
  endtask

  task automatic bound_fail(input string what);
    errors++;
    $display("FAIL %s: bound expired, got model state pos=%0d p1=%0d p2=%0d, required goal",
             what, m_pos, m_p1, m_p2);
  endtask

  // Monitor: every cycle after the edge, compare outputs with the oldest expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{leds, p1_score, p2_score, winner, round_active};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got leds=%b p1=%0d p2=%0d win=%b act=%b, required leds=%b p1=%0d p2=%0d win=%b act=%b",
                   $time, a.leds, a.p1, a.p2, a.winner, a.active,
                   e.leds, e.p1, e.p2, e.winner, e.active);
        end
      end
    end
  end

  initial begin
    int n;
    logic [1:0] fav;
    model_step(2'b00, 1'b1);
    // 1: reset then idle
    cyc(2'b00, 1'b1); cyc(2'b00, 1'b1);
    repeat (5) cyc(2'b00, 1'b0);
    // 2: P1 walks to the edge, wins, then lockout and re-centre
    repeat (5) begin cyc(2'b10, 1'b0); cyc(2'b00, 1'b0); end
    repeat (6) cyc(2'b00, 1'b0);
    // 3: ties hold, presses during lockout ignored
    repeat (10) cyc(2'b11, 1'b0);
    repeat (5) cyc(2'b10, 1'b0);
    repeat (LOCK + 2) cyc(2'b10, 1'b0);
    // 4: P2 wins the match, frozen afterwards, then reset
    cyc(2'b00, 1'b1);
    n = 0;
    while (!m_done && n < 500) begin cyc(2'b01, 1'b0); n++; end
    if (!m_done) bound_fail("p2_match");
    repeat (20) cyc(2'($urandom_range(0, 3)), 1'b0);
    cyc(2'b00, 1'b1);
    cyc(2'b00, 1'b0);
    // 5: P1 to score 3, light to pos 2, reset mid-round
    n = 0;
    while (m_p1 < 3 && n < 300) begin cyc(2'b10, 1'b0); n++; end
    n = 0;
    while (!playing() && n < 50) begin cyc(2'b00, 1'b0); n++; end
    if (m_p1 != 3 || !playing()) bound_fail("p1_three");
    cyc(2'b01, 1'b0); cyc(2'b01, 1'b0);
    cyc(2'b00, 1'b1);
    cyc(2'b00, 1'b0);
    // 6: alternating pulses never win
    repeat (10) begin cyc(2'b10, 1'b0); cyc(2'b01, 1'b0); end
    // Random: biased tug with occasional resets
    fav = 2'b10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) fav = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      cyc(($urandom_range(0, 9) < 6) ? fav : 2'($urandom_range(0, 3)),
          ($urandom_range(0, 399) == 0));
    end
    repeat (2) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
